// File: rtl/nebula_pkg.sv
// Shared types for the nebula link: flit type encoding, framing FSM states and a flit-type decoder.
package nebula_pkg;

  localparam int FLIT_TYPE_W = 2;
  localparam int FLIT_MAX_W  = 256;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } frame_state_e;

  // Callers zero-extend their flit to FLIT_MAX_W and pass the real width.
  function automatic flit_type_e flit_type(input logic [FLIT_MAX_W-1:0] flit, input int w);
    return flit_type_e'(FLIT_TYPE_W'(flit >> (w - FLIT_TYPE_W)));
  endfunction

endpackage

// File: rtl/nebula_credit_counter.sv
// Saturating downstream credit counter with a sticky overflow flag.
module nebula_credit_counter #(
  parameter int CREDITS = 16,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             overflow
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full;

  assign full = (count_q == CNT_W'(CREDITS));

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (dec && !inc) begin
      count_d = count_q - 1'b1;
    end else if (inc && !dec) begin
      // A return with every slot already home means the partner miscounted.
      if (full) ovf_d   = 1'b1;
      else      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CNT_W'(CREDITS);
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign nonzero  = (count_q != '0);
  assign overflow = ovf_q;

endmodule

// File: rtl/nebula_credit_tx.sv
// Credit-based link transmitter draining a nebula_fifo, with packet framing checks.
// Optional macro NEBULA_TX_PARITY_EN adds tx_parity output and chk_parity_inject input.
module nebula_credit_tx
  import nebula_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int CREDITS = 16,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_pop,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  input  logic             credit_return,
  output logic [CNT_W-1:0] credits,
  output logic             proto_err,
  output logic             credit_err,
`ifdef NEBULA_TX_PARITY_EN
  output logic             tx_parity,
  input  logic             chk_parity_inject,
`endif
  output logic             idle
);

  frame_state_e     state_q;
  logic             tx_valid_q;
  logic [WIDTH-1:0] tx_data_q;
  logic             proto_err_q;
  logic             cr_nonzero;
  flit_type_e       ft;

  nebula_credit_counter #(.CREDITS(CREDITS), .CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (credit_return),
    .dec      (fifo_pop),
    .count    (credits),
    .nonzero  (cr_nonzero),
    .overflow (credit_err)
  );

  // Gated on the registered count only, so a return never pops in its own cycle.
  assign fifo_pop = !fifo_empty && cr_nonzero && !rst;
  assign ft       = flit_type(FLIT_MAX_W'(fifo_dout), WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      tx_valid_q <= fifo_pop;
      if (fifo_pop) begin
        tx_data_q <= fifo_dout;
        state_q   <= (ft == HEAD || ft == BODY) ? ST_PKT : ST_IDLE;
        if (state_q == ST_IDLE && (ft == BODY || ft == TAIL)) proto_err_q <= 1'b1;
        if (state_q == ST_PKT  && (ft == HEAD || ft == SINGLE)) proto_err_q <= 1'b1;
      end
    end
  end

`ifdef NEBULA_TX_PARITY_EN
  logic tx_parity_q;
  always_ff @(posedge clk) begin
    if (rst)           tx_parity_q <= 1'b0;
    else if (fifo_pop) tx_parity_q <= (^fifo_dout) ^ chk_parity_inject;
  end
  assign tx_parity = tx_parity_q;
`endif

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign proto_err = proto_err_q;
  assign idle      = (state_q == ST_IDLE) && fifo_empty && !tx_valid_q &&
                     (credits == CNT_W'(CREDITS));

endmodule

// File: tb/tb_nebula_credit_tx.sv
// Directed bench for nebula_credit_tx with a behavioural FIFO front end.
module tb_nebula_credit_tx;

  localparam int WIDTH   = 64;
  localparam int CREDITS = 16;
  localparam int CNT_W   = $clog2(CREDITS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_pop;
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             credit_return;
  logic [CNT_W-1:0] credits;
  logic             proto_err;
  logic             credit_err;
  logic             idle;
`ifdef NEBULA_TX_PARITY_EN
  logic             tx_parity;
  logic             chk_parity_inject;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mem [0:63];
  logic [5:0]       wr_ptr = '0;
  logic [5:0]       rd_ptr = '0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = mem[rd_ptr];

  always @(posedge clk) if (fifo_pop) rd_ptr <= rd_ptr + 6'd1;

  nebula_credit_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_empty        (fifo_empty),
    .fifo_dout         (fifo_dout),
    .fifo_pop          (fifo_pop),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .credit_return     (credit_return),
    .credits           (credits),
    .proto_err         (proto_err),
    .credit_err        (credit_err),
`ifdef NEBULA_TX_PARITY_EN
    .tx_parity         (tx_parity),
    .chk_parity_inject (chk_parity_inject),
`endif
    .idle              (idle)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] mk(input logic [1:0] t, input int n);
    return {t, 62'(n)};
  endfunction

  task automatic push(input logic [WIDTH-1:0] f);
    mem[wr_ptr] = f;
    wr_ptr      = wr_ptr + 6'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    wr_ptr = rd_ptr;
    tick();
    rst = 1'b0;
  endtask

  task automatic return_credits(input int n);
    credit_return = 1'b1;
    repeat (n) tick();
    credit_return = 1'b0;
  endtask

`ifdef NEBULA_TX_PARITY_EN
  always @(negedge clk) if (!rst && tx_valid) chk("parity", tx_parity, ^tx_data);
`endif

  initial begin
    int sent;
    rst           = 1'b1;
    credit_return = 1'b0;
`ifdef NEBULA_TX_PARITY_EN
    chk_parity_inject = 1'b0;
`endif
    tick(); tick();
    chk("rst_credits",  credits, 64'(CREDITS));
    chk("rst_valid",    tx_valid, 0);
    chk("rst_data",     tx_data, 0);
    chk("rst_proto",    proto_err, 0);
    chk("rst_crerr",    credit_err, 0);
    chk("rst_pop",      fifo_pop, 0);
    rst = 1'b0;
    #1;
    chk("rst_idle",     idle, 1);

    // 1: three SINGLE flits back to back
    for (int i = 0; i < 3; i++) push(mk(2'b11, i + 1));
    #1;
    chk("t1_pop", fifo_pop, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_valid", tx_valid, 1);
      chk("t1_data",  tx_data, mk(2'b11, i + 1));
    end
    tick();
    chk("t1_gap",    tx_valid, 0);
    chk("t1_hold",   tx_data, mk(2'b11, 3));
    chk("t1_cred",   credits, 13);
    chk("t1_proto",  proto_err, 0);
    return_credits(3);
    chk("t1_home",   credits, 16);
    chk("t1_idle",   idle, 1);

    // 2: credit exhaustion with 20 queued
    push(mk(2'b01, 100));
    for (int i = 1; i < 20; i++) push(mk(2'b00, 100 + i));
    sent = 0;
    repeat (20) begin
      tick();
      if (tx_valid) sent++;
    end
    chk("t2_sent",   sent, 16);
    chk("t2_cred0",  credits, 0);
    chk("t2_nopop",  fifo_pop, 0);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("t2_cred1",  credits, 1);
    chk("t2_novld",  tx_valid, 0);
    chk("t2_pop1",   fifo_pop, 1);
    tick();
    chk("t2_one",    tx_valid, 1);
    chk("t2_data",   tx_data, mk(2'b00, 116));
    tick();
    chk("t2_stop",   tx_valid, 0);
    chk("t2_cred00", credits, 0);
    chk("t2_proto",  proto_err, 0);
    do_reset();

    // 3: pop and return coincide at credits=5
    push(mk(2'b01, 200));
    for (int i = 1; i < 11; i++) push(mk(2'b00, 200 + i));
    push(mk(2'b10, 211));
    repeat (11) tick();
    chk("t3_cred5",  credits, 5);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("t3_same",   credits, 5);
    chk("t3_valid",  tx_valid, 1);
    chk("t3_data",   tx_data, mk(2'b10, 211));
    tick();
    return_credits(11);
    chk("t3_home",   credits, 16);
    chk("t3_proto",  proto_err, 0);
    chk("t3_idle",   idle, 1);

    // 4: HEAD BODY TAIL then stray BODY
    push(mk(2'b01, 300));
    push(mk(2'b00, 301));
    push(mk(2'b10, 302));
    push(mk(2'b00, 303));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_clean",  proto_err, 0);
    end
    tick();
    chk("t4_err",    proto_err, 1);
    chk("t4_valid",  tx_valid, 1);
    chk("t4_data",   tx_data, mk(2'b00, 303));
    tick();
    return_credits(4);
    chk("t4_home",   credits, 16);
    chk("t4_pkt",    idle, 0);

    // 5: return with all credits home
    chk("t5_pre",    credit_err, 0);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("t5_cred",   credits, 16);
    chk("t5_err",    credit_err, 1);
    repeat (3) tick();
    chk("t5_sticky", credit_err, 1);
    chk("t5_psticky", proto_err, 1);

    // 6: reset mid-packet
    do_reset();
    chk("t6_clrp",   proto_err, 0);
    chk("t6_clrc",   credit_err, 0);
    push(mk(2'b01, 400));
    push(mk(2'b00, 401));
    push(mk(2'b00, 402));
    push(mk(2'b10, 403));
    tick(); tick();
    chk("t6_mid",    tx_data, mk(2'b00, 401));
    chk("t6_cred14", credits, 14);
    rst = 1'b1;
    #1;
    chk("t6_rstpop", fifo_pop, 0);
    tick();
    chk("t6_valid",  tx_valid, 0);
    chk("t6_cred",   credits, 16);
    chk("t6_proto",  proto_err, 0);
    chk("t6_crerr",  credit_err, 0);
    wr_ptr = rd_ptr;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle",   idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
